// File: rtl/accu_pkg.sv
// Shared sizing helpers, frame-length clamp and result-register layout
// for the streaming frame accumulator.
package accu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_N  = 16;

  // Widest possible frame sum: MAX_N * (2^DATA_W - 1) always fits.
  function automatic int sum_width(input int data_w, input int max_n);
    return data_w + $clog2(max_n);
  endfunction

  // Frame-length field must be able to hold MAX_N itself.
  function automatic int cnt_width(input int max_n);
    return $clog2(max_n) + 1;
  endfunction

  // 0 means a single-sample frame; anything above max_n saturates.
  function automatic int clamp_n(input int n_cfg, input int max_n);
    if (n_cfg < 1) return 1;
    if (n_cfg > max_n) return max_n;
    return n_cfg;
  endfunction

  localparam int DEF_SUM_W = sum_width(DEF_DATA_W, DEF_MAX_N);

  // Result register layout for the default configuration.
  typedef struct packed {
    logic [DEF_SUM_W-1:0] sum;
    logic                 vld;
  } result_t;

endpackage

// File: rtl/accu_out_reg.sv
// One-entry result holder: loads a finished frame sum, drains on the
// output handshake and reports when it cannot take a new result.
module accu_out_reg #(
  parameter int SUM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             ready_out,
  output logic [SUM_W-1:0] data_out,
  output logic             valid_out,
  output logic             stall
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a consume replaces the result in place.
      data_out  <= sum_in;
      valid_out <= 1'b1;
    end else if (valid_out && ready_out) begin
      valid_out <= 1'b0;
    end
  end

  assign stall = valid_out && !ready_out;

endmodule

// File: rtl/accu_stream.sv
// Streaming accumulator: sums 1..MAX_N unsigned samples per frame and hands
// each frame sum to a backpressured consumer through a one-entry register.
module accu_stream
  import accu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int MAX_N  = 16,
  localparam int SUM_W  = sum_width(DATA_W, MAX_N),
  localparam int CNT_W  = cnt_width(MAX_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  n_cfg,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [SUM_W-1:0]  data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              busy
);

  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] n_eff;
  logic             last;
  logic             accept;
  logic             stall;
  logic             load;

  assign n_eff    = CNT_W'(clamp_n(int'(n_cfg), MAX_N));
  // First beat decides from the live n_cfg, later beats from the latched length.
  assign last     = (cnt == '0) ? (n_eff == CNT_W'(1)) : (cnt == n_lat - CNT_W'(1));
  assign sum_next = acc + SUM_W'(data_in);
  // Only the closing beat can be held off, and only while the result is stuck.
  assign ready_in = !(last && stall);
  assign accept   = valid_in && ready_in;
  assign load     = accept && last && !clear;
  assign busy     = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      n_lat <= '0;
    end else if (clear) begin
      // Abort drops any beat presented alongside it, even a closing one.
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (cnt == '0) n_lat <= n_eff;
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_next;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  accu_out_reg #(
    .SUM_W(SUM_W)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .sum_in   (sum_next),
    .ready_out(ready_out),
    .data_out (data_out),
    .valid_out(valid_out),
    .stall    (stall)
  );

endmodule
